recon_mul_113: RTL

- Sequential reconstructor for the constant-divide-by-113 datapath; it is the inverse of the 24-bit quotient/remainder generator.
- Accepts a quotient q and remainder r, and rebuilds the dividend x = q*DIVISOR + r.
- Works digit-serially, MSB-first, one CHUNK-bit quotient digit per cycle using Horner accumulation.
- Sits behind the divider in self-check and round-trip datapaths, with valid/ready handshakes on both sides.

---
 rtl/recon_mul_113.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/recon_mul_113.sv
`default_nettype none
// ============================================================================
// Module      : recon_mul_113
// Description : Digit-serial MSB-first reconstructor x = q*DIVISOR + r.
//               Optional range/overflow flag under macro RECON_CHECK_EN.
// Revision    : 1.0
// ============================================================================
module recon_mul_113 #(
    parameter int WIDTH   = 24,
    parameter int DIVISOR = 113,
    parameter int QW      = 18,
    parameter int RW      = 7,
    parameter int CHUNK   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [QW-1:0]    q_in,
    input  logic [RW-1:0]    r_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x_out,
    output logic             err
);

    localparam int NDIG = QW / CHUNK;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int AW   = QW + RW + 1;
    // Accumulator keeps at least one bit above WIDTH so overflow is observable.
    localparam int FW   = (AW > WIDTH) ? AW : WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [QW-1:0]    qs_q, qs_d;
    logic [RW-1:0]    rs_q, rs_d;
    logic [FW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic             ov_q, ov_d;

    logic [CHUNK-1:0] w_digit;
    logic [FW-1:0]    w_step;
    logic [WIDTH-1:0] w_x;
    logic             w_last;

    assign w_digit = qs_q[QW-1 -: CHUNK];
    assign w_step  = (acc_q << CHUNK) + FW'(w_digit) * FW'(DIVISOR);
    assign w_x     = w_step[WIDTH-1:0] + WIDTH'(rs_q);
    assign w_last  = (cnt_q == CW'(NDIG - 1));

    assign in_ready  = (state_q == IDLE);
    assign out_valid = ov_q;
    assign x_out     = x_q;

    always_comb begin
        state_d = state_q;
        qs_d    = qs_q;
        rs_d    = rs_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        ov_d    = ov_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    qs_d    = q_in;
                    rs_d    = r_in;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = w_step;
                qs_d  = qs_q << CHUNK;
                cnt_d = cnt_q + CW'(1);
                if (w_last) begin
                    x_d     = w_x;
                    ov_d    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    ov_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            qs_q    <= '0;
            rs_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            x_q     <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            qs_q    <= qs_d;
            rs_q    <= rs_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            ov_q    <= ov_d;
        end
    end

`ifdef RECON_CHECK_EN
    logic [FW-1:0] w_full;
    logic          err_q, err_d;

    assign w_full = w_step + FW'(rs_q);

    always_comb begin
        err_d = err_q;
        if (state_q == RUN && w_last) begin
            err_d = (FW'(rs_q) >= FW'(DIVISOR)) || (|w_full[FW-1:WIDTH]);
        end else if (state_q == DONE && out_ready) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
`default_nettype wire
